// File: rtl/sram_pkg.sv
// Shared types and defaults for the parametrised asynchronous SRAM controller.
package sram_pkg;

    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_ADDR_W = 20;
    localparam int WAIT_CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        DONE     = 3'd5
    } sram_state_t;

endpackage

// File: rtl/sram_ctrl_param.sv
// Single-port async SRAM controller: read = READ_WAIT+2 cycles to resp, write = WRITE_WAIT+4.
// One request in flight; req_ready only in IDLE/DONE, so the core stalls while an access runs.
module sram_ctrl_param
    import sram_pkg::*;
#(
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1,
    localparam int BE_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [BE_W-1:0]   ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
        $fatal(1, "sram_ctrl_param: DATA_W must be a non-zero multiple of 8");
    end
    if (READ_WAIT < 0 || READ_WAIT > 15) begin : g_bad_read_wait
        $fatal(1, "sram_ctrl_param: READ_WAIT must be within 0..15");
    end
    if (WRITE_WAIT < 0 || WRITE_WAIT > 15) begin : g_bad_write_wait
        $fatal(1, "sram_ctrl_param: WRITE_WAIT must be within 0..15");
    end

    localparam logic [WAIT_CNT_W-1:0] RD_CNT = WAIT_CNT_W'(READ_WAIT);
    localparam logic [WAIT_CNT_W-1:0] WR_CNT = WAIT_CNT_W'(WRITE_WAIT);

    sram_state_t           state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [BE_W-1:0]       be_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [DATA_W-1:0]     be_mask;
    logic                  be_zero;
    logic                  accept;
    logic                  drive;

    assign be_zero = ~|be_q;
    assign accept  = req_valid && req_ready;

    always_comb begin
        be_mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            be_mask[i*8 +: 8] = {8{be_q[i]}};
        end
    end

    // A zero-enable request still walks through its first state, with strobes held off.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ram_ce_n   = 1'b1;
        ram_oe_n   = 1'b1;
        ram_we_n   = 1'b1;
        ram_be_n   = '1;
        drive      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                req_ready  = !rst;
                resp_valid = (state_q == DONE);
                if (accept) begin
                    state_d = req_we ? WR_SETUP : RD;
                    cnt_d   = req_we ? WR_CNT : RD_CNT;
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                ram_ce_n = be_zero;
                ram_oe_n = be_zero;
                ram_be_n = ~be_q;
                if (be_zero || cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_SETUP: begin
                ram_ce_n = be_zero;
                ram_be_n = ~be_q;
                drive    = !be_zero;
                state_d  = be_zero ? DONE : WR_PULSE;
            end
            WR_PULSE: begin
                ram_ce_n = 1'b0;
                ram_we_n = 1'b0;
                ram_be_n = ~be_q;
                drive    = 1'b1;
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_HOLD: begin
                ram_ce_n = 1'b0;
                ram_be_n = ~be_q;
                drive    = 1'b1;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            // Disabled lanes are forced to zero so a partial read never leaks stale bytes.
            if (state_q == RD && state_d == DONE) begin
                rdata_q <= ram_data & be_mask;
            end
        end
    end

    assign ram_data   = drive ? wdata_q : 'z;
    assign ram_addr   = addr_q;
    assign resp_rdata = rdata_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Directed bench for sram_ctrl_param (READ_WAIT = WRITE_WAIT = 1) against a 16-word SRAM model.
module tb_sram_ctrl_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [19:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        busy;
    wire  [31:0] ram_data;
    logic [19:0] ram_addr;
    logic [3:0]  ram_be_n;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;

    int errors = 0;
    int checks = 0;

    sram_ctrl_param dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .busy       (busy),
        .ram_data   (ram_data),
        .ram_addr   (ram_addr),
        .ram_be_n   (ram_be_n),
        .ram_ce_n   (ram_ce_n),
        .ram_oe_n   (ram_oe_n),
        .ram_we_n   (ram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM model: word index is the low nibble of the address; writes commit on WE rising.
    logic [31:0] mem [16];
    assign ram_data = (ram_ce_n == 1'b0 && ram_oe_n == 1'b0 && ram_we_n == 1'b1)
                      ? mem[ram_addr[3:0]] : 'z;

    always @(posedge ram_we_n) begin
        if (ram_ce_n == 1'b0) begin
            for (int i = 0; i < 4; i++) begin
                if (!ram_be_n[i]) mem[ram_addr[3:0]][i*8 +: 8] <= ram_data[i*8 +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one request and follows it to resp_valid; lat counts cycles after the accept edge.
    task automatic access(input logic we, input logic [19:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output int lat, output int ce_lo,
                          output int oe_lo, output int we_lo, output logic [31:0] bus1,
                          output logic [3:0] ben1);
        lat = 0; ce_lo = 0; oe_lo = 0; we_lo = 0; bus1 = '0; ben1 = '0;
        check("ready_before_req", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        tick;
        req_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) begin
                bus1 = ram_data;
                ben1 = ram_be_n;
            end
            if (!ram_ce_n) ce_lo++;
            if (!ram_oe_n) oe_lo++;
            if (!ram_we_n) we_lo++;
            if (resp_valid) begin
                lat = c;
                break;
            end
            tick;
        end
    endtask

    int          lat, ce_lo, oe_lo, we_lo, seen;
    logic [31:0] bus1;
    logic [3:0]  ben1;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        tick; tick;

        check("rst_ready", req_ready, 0);
        check("rst_ce_n", ram_ce_n, 1);
        check("rst_oe_n", ram_oe_n, 1);
        check("rst_we_n", ram_we_n, 1);
        check("rst_be_n", ram_be_n, 4'hF);
        check("rst_addr", ram_addr, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_bus_hiz", dut.drive, 0);
        rst = 1'b0;
        tick;
        check("idle_ready", req_ready, 1);
        check("idle_resp_valid", resp_valid, 0);

        // Full write then read back.
        access(1'b1, 20'h00012, 32'hDEADBEEF, 4'hF, lat, ce_lo, oe_lo, we_lo, bus1, ben1);
        check("wr_latency", lat, 5);
        check("wr_we_low_cycles", we_lo, 2);
        check("wr_ce_low_cycles", ce_lo, 4);
        check("wr_oe_low_cycles", oe_lo, 0);
        check("wr_setup_bus", bus1, 32'hDEADBEEF);
        check("wr_done_busy", busy, 1);
        check("wr_done_bus_hiz", dut.drive, 0);
        check("wr_rdata_unchanged", resp_rdata, 0);
        tick;
        check("wr_resp_one_cycle", resp_valid, 0);
        check("wr_back_idle_busy", busy, 0);

        access(1'b0, 20'h00012, 32'h0, 4'hF, lat, ce_lo, oe_lo, we_lo, bus1, ben1);
        check("rd_latency", lat, 3);
        check("rd_oe_low_cycles", oe_lo, 2);
        check("rd_we_low_cycles", we_lo, 0);
        check("rd_data", resp_rdata, 32'hDEADBEEF);
        check("rd_done_ce_n", ram_ce_n, 1);

        // Partial write at the all-ones address.
        access(1'b1, 20'hFFFFF, 32'hDEADBEEF, 4'hF, lat, ce_lo, oe_lo, we_lo, bus1, ben1);
        check("top_wr_latency", lat, 5);
        access(1'b1, 20'hFFFFF, 32'h0000AB00, 4'b0010, lat, ce_lo, oe_lo, we_lo, bus1, ben1);
        check("part_wr_latency", lat, 5);
        check("part_wr_be_n", ben1, 4'b1101);
        check("part_wr_bus", bus1, 32'h0000AB00);
        check("top_addr_verbatim", ram_addr, 20'hFFFFF);
        access(1'b0, 20'hFFFFF, 32'h0, 4'hF, lat, ce_lo, oe_lo, we_lo, bus1, ben1);
        check("part_rd_full", resp_rdata, 32'hDEADABEF);
        access(1'b0, 20'hFFFFF, 32'h0, 4'b0001, lat, ce_lo, oe_lo, we_lo, bus1, ben1);
        check("part_rd_lane0", resp_rdata, 32'h000000EF);
        check("part_rd_be_n", ben1, 4'b1110);
        tick; tick;
        check("rdata_held", resp_rdata, 32'h000000EF);

        // Back-to-back: read, then write accepted in the read's DONE cycle.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 20'h00012; req_be = 4'hF;
        tick;
        check("b2b_c1_ce_n", ram_ce_n, 0);
        req_we = 1'b1; req_addr = 20'h00013; req_wdata = 32'h12345678;
        tick;
        check("b2b_c2_ce_n", ram_ce_n, 0);
        check("b2b_c2_ready", req_ready, 0);
        tick;
        check("b2b_done_resp", resp_valid, 1);
        check("b2b_done_ready", req_ready, 1);
        check("b2b_done_ce_n", ram_ce_n, 1);
        check("b2b_rd_data", resp_rdata, 32'hDEADBEEF);
        tick;
        req_valid = 1'b0;
        check("b2b_wr_setup_ce_n", ram_ce_n, 0);
        check("b2b_wr_setup_resp", resp_valid, 0);
        for (int c = 0; c < 20; c++) begin
            if (resp_valid) break;
            tick;
        end
        check("b2b_wr_done", resp_valid, 1);
        access(1'b0, 20'h00013, 32'h0, 4'hF, lat, ce_lo, oe_lo, we_lo, bus1, ben1);
        check("b2b_readback", resp_rdata, 32'h12345678);

        // Reset during the second WE-low cycle.
        tick;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h00014; req_wdata = 32'hAAAA5555;
        req_be = 4'hF;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        check("abort_in_pulse2", ram_we_n, 0);
        rst = 1'b1;
        tick;
        check("abort_ce_n", ram_ce_n, 1);
        check("abort_we_n", ram_we_n, 1);
        check("abort_oe_n", ram_oe_n, 1);
        check("abort_bus_hiz", dut.drive, 0);
        check("abort_resp", resp_valid, 0);
        check("abort_ready_in_rst", req_ready, 0);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid) seen++;
            tick;
        end
        check("abort_no_resp", seen, 0);
        access(1'b1, 20'h00014, 32'h13572468, 4'hF, lat, ce_lo, oe_lo, we_lo, bus1, ben1);
        check("rewrite_latency", lat, 5);
        access(1'b0, 20'h00014, 32'h0, 4'hF, lat, ce_lo, oe_lo, we_lo, bus1, ben1);
        check("rewrite_readback", resp_rdata, 32'h13572468);

        // Zero byte-enable read and write.
        access(1'b0, 20'h00012, 32'h0, 4'h0, lat, ce_lo, oe_lo, we_lo, bus1, ben1);
        check("zbe_rd_latency", lat, 2);
        check("zbe_rd_ce_low", ce_lo, 0);
        check("zbe_rd_oe_low", oe_lo, 0);
        check("zbe_rd_data", resp_rdata, 0);
        access(1'b1, 20'h00012, 32'h55555555, 4'h0, lat, ce_lo, oe_lo, we_lo, bus1, ben1);
        check("zbe_wr_latency", lat, 2);
        check("zbe_wr_ce_low", ce_lo, 0);
        check("zbe_wr_we_low", we_lo, 0);
        access(1'b0, 20'h00012, 32'h0, 4'hF, lat, ce_lo, oe_lo, we_lo, bus1, ben1);
        check("zbe_wr_no_effect", resp_rdata, 32'hDEADBEEF);

        tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
